// File: rtl/fp_pkg.sv
// fp_pkg: field widths, FSM state type and result record shared by int_to_fp and fp_adder.
package fp_pkg;

    localparam int EXP_W  = 4;
    localparam int FRAC_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } fsm_state_t;

    typedef struct packed {
        logic              sign;
        logic [EXP_W-1:0]  exp;
        logic [FRAC_W-1:0] frac;
        logic              ovf;
    } fp_result_t;

endpackage

// File: rtl/fp_round.sv
// fp_round: round-half-up of a normalised significand from one guard bit, saturating when the
// exponent cannot absorb the carry. Only compiled when FP_ROUND_EN is defined.
`ifdef FP_ROUND_EN
module fp_round
    import fp_pkg::*;
(
    input  logic [FRAC_W-1:0] i_frac,
    input  logic [EXP_W-1:0]  i_exp,
    input  logic              i_guard,
    output logic [FRAC_W-1:0] o_frac,
    output logic [EXP_W-1:0]  o_exp,
    output logic              o_ovf
);
    localparam int SUM_W = FRAC_W + 1;

    logic [SUM_W-1:0] w_sum;

    assign w_sum = {1'b0, i_frac} + SUM_W'(i_guard);

    // NOTE: every output gets a default before the branches so no latch is inferred.
    always_comb begin
        o_frac = w_sum[FRAC_W-1:0];
        o_exp  = i_exp;
        o_ovf  = 1'b0;
        if (w_sum[FRAC_W]) begin
            if (i_exp == '1) begin
                o_frac = '1;
                o_ovf  = 1'b1;
            end else begin
                o_frac = {1'b1, {(FRAC_W-1){1'b0}}};
                o_exp  = i_exp + EXP_W'(1);
            end
        end
    end

endmodule
`endif

// File: rtl/int_to_fp.sv
// int_to_fp: two's-complement integer to sign / unbiased exponent / 0.frac, normalised one bit
// per cycle. Truncates by default; define FP_ROUND_EN to round half up through fp_round.
module int_to_fp
    import fp_pkg::*;
#(
    parameter int INT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [INT_W-1:0]  in_data,
    output logic              in_ready,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              sign_out,
    output logic [EXP_W-1:0]  exp_out,
    output logic [FRAC_W-1:0] frac_out,
    output logic              ovf
);
    localparam int SHIFT_W   = 16;
    localparam int PRE_SHIFT = SHIFT_W - INT_W + 1;

    fsm_state_t         r_state;
    logic               r_in_ready;
    logic               r_out_valid;
    logic               r_sign;
    logic [SHIFT_W-1:0] r_shift;
    logic [EXP_W-1:0]   r_exp;
    fp_result_t         r_result;

    logic [INT_W-1:0]   w_mag;
    logic [FRAC_W-1:0]  w_frac;
    logic [EXP_W-1:0]   w_exp;
    logic               w_ovf;

    assign w_mag = in_data[INT_W-1] ? (~in_data + INT_W'(1)) : in_data;

`ifdef FP_ROUND_EN
    fp_round u_fp_round (
        .i_frac  (r_shift[SHIFT_W-1 -: FRAC_W]),
        .i_exp   (r_exp),
        .i_guard (r_shift[SHIFT_W-FRAC_W-1]),
        .o_frac  (w_frac),
        .o_exp   (w_exp),
        .o_ovf   (w_ovf)
    );
`else
    assign w_frac = r_shift[SHIFT_W-1 -: FRAC_W];
    assign w_exp  = r_exp;
    assign w_ovf  = 1'b0;
`endif

    // NOTE: all state, including the datapath registers, is reset and updated with <= only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_sign      <= 1'b0;
            r_shift     <= '0;
            r_exp       <= '0;
            r_result    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_sign     <= in_data[INT_W-1];
                        r_in_ready <= 1'b0;
                        if (w_mag == '0) begin
                            r_result    <= '0;
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else if (w_mag[INT_W-1]) begin
                            // Only the most negative input has no positive counterpart.
                            r_result    <= '{sign: 1'b1, exp: EXP_W'(INT_W-1), frac: '1, ovf: 1'b1};
                            r_out_valid <= 1'b1;
                            r_state     <= DONE;
                        end else begin
                            r_shift <= SHIFT_W'(w_mag) << PRE_SHIFT;
                            r_exp   <= EXP_W'(INT_W-1);
                            r_state <= NORM;
                        end
                    end
                end
                NORM: begin
                    if (!r_shift[SHIFT_W-1]) begin
                        r_shift <= {r_shift[SHIFT_W-2:0], 1'b0};
                        r_exp   <= r_exp - EXP_W'(1);
                    end else begin
                        r_result    <= '{sign: r_sign, exp: w_exp, frac: w_frac, ovf: w_ovf};
                        r_out_valid <= 1'b1;
                        r_state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_state     <= IDLE;
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign sign_out  = r_result.sign;
    assign exp_out   = r_result.exp;
    assign frac_out  = r_result.frac;
    assign ovf       = r_result.ovf;

endmodule
